// File: rtl/kernel_test_framework_if.sv
// GPU-facing bus of the kernel test harness: launch/control strobes plus the
// program-read, data-read and data-write memory channels.
interface kernel_test_framework_if #(
  parameter int DATA_CH = 4,
  parameter int PROG_CH = 1
);
  logic                     gpu_dcr_we;
  logic [7:0]               gpu_dcr_data;
  logic                     gpu_start;
  logic                     gpu_reset;
  logic                     gpu_done;

  logic [PROG_CH-1:0]       prog_rd_valid;
  logic [PROG_CH-1:0][7:0]  prog_rd_addr;
  logic [PROG_CH-1:0]       prog_rd_ready;
  logic [PROG_CH-1:0][15:0] prog_rd_data;

  logic [DATA_CH-1:0]       data_rd_valid;
  logic [DATA_CH-1:0][7:0]  data_rd_addr;
  logic [DATA_CH-1:0]       data_rd_ready;
  logic [DATA_CH-1:0][7:0]  data_rd_data;

  logic [DATA_CH-1:0]       data_wr_valid;
  logic [DATA_CH-1:0][7:0]  data_wr_addr;
  logic [DATA_CH-1:0][7:0]  data_wr_data;
  logic [DATA_CH-1:0]       data_wr_ready;

  // GPU core side
  modport master (
    input  gpu_dcr_we, gpu_dcr_data, gpu_start, gpu_reset,
    output gpu_done,
    output prog_rd_valid, prog_rd_addr, input prog_rd_ready, prog_rd_data,
    output data_rd_valid, data_rd_addr, input data_rd_ready, data_rd_data,
    output data_wr_valid, data_wr_addr, data_wr_data, input data_wr_ready
  );

  // harness side, serving the memory requests
  modport slave (
    output gpu_dcr_we, gpu_dcr_data, gpu_start, gpu_reset,
    input  gpu_done,
    input  prog_rd_valid, prog_rd_addr, output prog_rd_ready, prog_rd_data,
    input  data_rd_valid, data_rd_addr, output data_rd_ready, data_rd_data,
    input  data_wr_valid, data_wr_addr, data_wr_data, output data_wr_ready
  );
endinterface

// File: rtl/kernel_test_framework.sv
// Kernel test harness: host-loaded program/data/golden memories, kernel launch, memory
// serving and golden compare. Optional watchdog enabled by macro FW_TIMEOUT_EN.
module kernel_test_framework #(
  parameter int DATA_CH        = 4,
  parameter int PROG_CH        = 1,
  parameter int MEM_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_we,
  input  logic [1:0]  host_sel,
  input  logic [7:0]  host_addr,
  input  logic [15:0] host_wdata,
  input  logic [8:0]  golden_len,
  input  logic [7:0]  thread_count,
  input  logic        run,
  output logic        busy,
  output logic        done,
  output logic [15:0] return_code,
  input  logic [7:0]  dbg_addr,
  output logic [7:0]  dbg_data,
  output logic [7:0]  dbg_golden,
  kernel_test_framework_if.slave gpu
);
  localparam logic [2:0] S_IDLE = 3'd0, S_LAUNCH1 = 3'd1, S_LAUNCH2 = 3'd2,
                         S_RUN  = 3'd3, S_CHECK   = 3'd4, S_DONE    = 3'd5;
  localparam int             LW     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LW-1:0]  LAT_M1 = LW'(MEM_LATENCY - 1);

  logic [15:0] prog_mem   [256];
  logic [7:0]  data_mem   [256];
  logic [7:0]  golden_mem [256];

  logic [2:0]  state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic [15:0] mm_q, mm_d, rc_q, rc_d;
  logic        chk_neq, chk_last, tmo_hit, serve;

  assign serve    = (state_q == S_RUN) && !reset;
  assign chk_neq  = data_mem[idx_q[7:0]] != golden_mem[idx_q[7:0]];
  assign chk_last = idx_q == (golden_len - 9'd1);

`ifdef FW_TIMEOUT_EN
  logic [31:0] tmo_q;
  always_ff @(posedge clk) begin
    if (reset || state_q != S_RUN) tmo_q <= '0;
    else                           tmo_q <= tmo_q + 32'd1;
  end
  assign tmo_hit = (state_q == S_RUN) && (tmo_q == 32'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mm_d    = mm_q;
    rc_d    = rc_q;
    case (state_q)
      S_IDLE:    if (run) state_d = S_LAUNCH1;
      S_LAUNCH1: state_d = S_LAUNCH2;
      S_LAUNCH2: state_d = S_RUN;
      S_RUN: begin
        if (gpu.gpu_done) begin
          state_d = S_CHECK;
          idx_d   = '0;
          mm_d    = '0;
        end else if (tmo_hit) begin
          state_d = S_DONE;
          rc_d    = 16'hFFFF;
        end
      end
      S_CHECK: begin
        if (golden_len == 9'd0) begin
          state_d = S_DONE;
          rc_d    = '0;
        end else begin
          // saturate below 0xFFFF so a mismatch count never aliases the timeout code
          if (chk_neq && mm_q != 16'hFFFE) mm_d = mm_q + 16'd1;
          idx_d = idx_q + 9'd1;
          if (chk_last) begin
            state_d = S_DONE;
            rc_d    = mm_d;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mm_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mm_q    <= mm_d;
      rc_q    <= rc_d;
    end
  end

  assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done             = state_q == S_DONE;
  assign return_code      = rc_q;
  assign gpu.gpu_reset    = state_q == S_IDLE;
  assign gpu.gpu_dcr_we   = state_q == S_LAUNCH1;
  assign gpu.gpu_dcr_data = thread_count;
  assign gpu.gpu_start    = (state_q == S_LAUNCH2) || (state_q == S_RUN);
  assign dbg_data         = data_mem[dbg_addr];
  assign dbg_golden       = golden_mem[dbg_addr];

  logic [PROG_CH-1:0]       prd_rdy;
  logic [PROG_CH-1:0][15:0] prd_dat;
  logic [DATA_CH-1:0]       drd_rdy, dwr_rdy, dwr_fire;
  logic [DATA_CH-1:0][7:0]  drd_dat;

  // Each channel: count MEM_LATENCY cycles of valid, then hold ready until valid drops.
  for (genvar c = 0; c < PROG_CH; c++) begin : g_prog
    logic [LW-1:0] cnt_q;
    logic          rdy_q, fire;
    logic [15:0]   dat_q;
    assign fire = serve && gpu.prog_rd_valid[c] && !rdy_q && (cnt_q == LAT_M1);
    always_ff @(posedge clk) begin
      if (reset || !serve || !gpu.prog_rd_valid[c]) begin
        cnt_q <= '0;
        rdy_q <= 1'b0;
      end else if (fire) rdy_q <= 1'b1;
      else if (!rdy_q)   cnt_q <= cnt_q + 1'b1;
    end
    always_ff @(posedge clk) if (fire) dat_q <= prog_mem[gpu.prog_rd_addr[c]];
    assign prd_rdy[c] = rdy_q;
    assign prd_dat[c] = dat_q;
  end

  for (genvar c = 0; c < DATA_CH; c++) begin : g_drd
    logic [LW-1:0] cnt_q;
    logic          rdy_q, fire;
    logic [7:0]    dat_q;
    assign fire = serve && gpu.data_rd_valid[c] && !rdy_q && (cnt_q == LAT_M1);
    always_ff @(posedge clk) begin
      if (reset || !serve || !gpu.data_rd_valid[c]) begin
        cnt_q <= '0;
        rdy_q <= 1'b0;
      end else if (fire) rdy_q <= 1'b1;
      else if (!rdy_q)   cnt_q <= cnt_q + 1'b1;
    end
    always_ff @(posedge clk) if (fire) dat_q <= data_mem[gpu.data_rd_addr[c]];
    assign drd_rdy[c] = rdy_q;
    assign drd_dat[c] = dat_q;
  end

  for (genvar c = 0; c < DATA_CH; c++) begin : g_dwr
    logic [LW-1:0] cnt_q;
    logic          rdy_q;
    assign dwr_fire[c] = serve && gpu.data_wr_valid[c] && !rdy_q && (cnt_q == LAT_M1);
    always_ff @(posedge clk) begin
      if (reset || !serve || !gpu.data_wr_valid[c]) begin
        cnt_q <= '0;
        rdy_q <= 1'b0;
      end else if (dwr_fire[c]) rdy_q <= 1'b1;
      else if (!rdy_q)          cnt_q <= cnt_q + 1'b1;
    end
    assign dwr_rdy[c] = rdy_q;
  end

  assign gpu.prog_rd_ready = prd_rdy;
  assign gpu.prog_rd_data  = prd_dat;
  assign gpu.data_rd_ready = drd_rdy;
  assign gpu.data_rd_data  = drd_dat;
  assign gpu.data_wr_ready = dwr_rdy;

  // Later loop iterations override earlier ones: highest channel wins on a shared address.
  always_ff @(posedge clk) begin
    if (!reset && state_q == S_IDLE && host_we) begin
      case (host_sel)
        2'd0:    prog_mem[host_addr]   <= host_wdata;
        2'd1:    data_mem[host_addr]   <= host_wdata[7:0];
        2'd2:    golden_mem[host_addr] <= host_wdata[7:0];
        default: ;
      endcase
    end
    for (int c = 0; c < DATA_CH; c++)
      if (dwr_fire[c]) data_mem[gpu.data_wr_addr[c]] <= gpu.data_wr_data[c];
  end
endmodule

// File: tb/tb_kernel_test_framework.sv
// Self-checking bench: behavioural GPU master runs a 3x4 * 4x5 matmul through the harness;
// read data and return codes are checked through scoreboard queues.
module tb_kernel_test_framework;
  logic        clk = 1'b0;
  logic        reset, host_we, run;
  logic [1:0]  host_sel;
  logic [7:0]  host_addr, thread_count, dbg_addr, dbg_data, dbg_golden;
  logic [15:0] host_wdata, return_code;
  logic [8:0]  golden_len;
  logic        busy, done;

  kernel_test_framework_if #(.DATA_CH(4), .PROG_CH(1)) gif ();

  kernel_test_framework #(
    .DATA_CH(4), .PROG_CH(1), .MEM_LATENCY(1), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .reset(reset), .host_we(host_we), .host_sel(host_sel),
    .host_addr(host_addr), .host_wdata(host_wdata), .golden_len(golden_len),
    .thread_count(thread_count), .run(run), .busy(busy), .done(done),
    .return_code(return_code), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_golden(dbg_golden), .gpu(gif)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_err = 0;
  logic [15:0] pmem_m [256];
  logic [7:0]  dmem_m [256];
  logic [7:0]  gmem_m [256];
  logic [15:0] rd_exp_q [$];
  logic [15:0] rc_exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [1:0] sel, input logic [7:0] a, input logic [15:0] d);
    host_we = 1'b1; host_sel = sel; host_addr = a; host_wdata = d;
    tick();
    host_we = 1'b0;
    case (sel)
      2'd0:    pmem_m[a] = d;
      2'd1:    dmem_m[a] = d[7:0];
      2'd2:    gmem_m[a] = d[7:0];
      default: ;
    endcase
  endtask

  task automatic prog_read(input logic [7:0] a);
    int n = 0;
    gif.prog_rd_valid[0] = 1'b1; gif.prog_rd_addr[0] = a;
    rd_exp_q.push_back(pmem_m[a]);
    do begin tick(); n++; end while (!gif.prog_rd_ready[0] && n < 20);
    chk("prog_rdy", gif.prog_rd_ready[0], 1);
    chk("prog_data", gif.prog_rd_data[0], rd_exp_q.pop_front());
    gif.prog_rd_valid[0] = 1'b0;
    tick();
  endtask

  task automatic data_read(input int ch, input logic [7:0] a, output logic [7:0] d);
    int n = 0;
    gif.data_rd_valid[ch] = 1'b1; gif.data_rd_addr[ch] = a;
    rd_exp_q.push_back({8'h00, dmem_m[a]});
    do begin tick(); n++; end while (!gif.data_rd_ready[ch] && n < 20);
    d = gif.data_rd_data[ch];
    chk("rd_rdy", gif.data_rd_ready[ch], 1);
    chk("rd_data", d, rd_exp_q.pop_front());
    gif.data_rd_valid[ch] = 1'b0;
    tick();
  endtask

  task automatic data_write(input int ch, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    gif.data_wr_valid[ch] = 1'b1; gif.data_wr_addr[ch] = a; gif.data_wr_data[ch] = d;
    do begin tick(); n++; end while (!gif.data_wr_ready[ch] && n < 20);
    chk("wr_rdy", gif.data_wr_ready[ch], 1);
    gif.data_wr_valid[ch] = 1'b0;
    tick();
    dmem_m[a] = d;
  endtask

  // returns in the first RUN cycle
  task automatic launch(input logic [7:0] tc);
    thread_count = tc; run = 1'b1;
    tick();
    run = 1'b0;
    chk("dcr_we", gif.gpu_dcr_we, 1);
    chk("dcr_data", gif.gpu_dcr_data, tc);
    chk("launch_gpu_rst", gif.gpu_reset, 0);
    chk("launch_busy", busy, 1);
    tick();
    chk("start", gif.gpu_start, 1);
    chk("dcr_we_off", gif.gpu_dcr_we, 0);
    tick();
  endtask

  task automatic finish_kernel();
    int n = 0;
    gif.gpu_done = 1'b1;
    tick();
    gif.gpu_done = 1'b0;
    chk("start_off", gif.gpu_start, 0);
    while (!done && n < 400) begin tick(); n++; end
    chk("done", done, 1);
    chk("rc", return_code, rc_exp_q.pop_front());
    chk("busy_at_done", busy, 0);
    tick();
    chk("done_pulse", done, 0);
    chk("idle_gpu_rst", gif.gpu_reset, 1);
  endtask

  // thread t computes C[t/5][t%5]; channels rotate with the thread id
  task automatic gpu_matmul();
    logic [7:0] a, b, acc;
    for (int i = 0; i < 35; i++) prog_read(8'(i));
    for (int t = 0; t < 15; t++) begin
      acc = 8'h00;
      for (int n = 0; n < 4; n++) begin
        data_read(t % 4, 8'(3 + (t / 5) * 4 + n), a);
        data_read((t + 1) % 4, 8'(15 + n * 5 + t % 5), b);
        acc = acc + a * b;
      end
      data_write(t % 4, 8'(35 + t), acc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] acc;
    int         n;
    logic       seen;
    reset = 1'b1; host_we = 1'b0; host_sel = '0; host_addr = '0; host_wdata = '0;
    golden_len = '0; thread_count = '0; run = 1'b0; dbg_addr = '0;
    gif.gpu_done = 1'b0;
    gif.prog_rd_valid = '0; gif.prog_rd_addr = '0;
    gif.data_rd_valid = '0; gif.data_rd_addr = '0;
    gif.data_wr_valid = '0; gif.data_wr_addr = '0; gif.data_wr_data = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rc", return_code, 0);
    chk("rst_gpu_rst", gif.gpu_reset, 1);
    chk("rst_start", gif.gpu_start, 0);
    chk("rst_dcr_we", gif.gpu_dcr_we, 0);
    chk("rst_prog_rdy", gif.prog_rd_ready, 0);
    chk("rst_rd_rdy", gif.data_rd_ready, 0);
    chk("rst_wr_rdy", gif.data_wr_ready, 0);
    reset = 1'b0;
    tick();

    // matmul image: dims, A (3x4), B (4x5), zeroed C (3x5); kernel words are placeholders
    for (int i = 0; i < 35; i++) host_write(2'd0, 8'(i), 16'($urandom));
    host_write(2'd1, 8'd0, 16'd3);
    host_write(2'd1, 8'd1, 16'd4);
    host_write(2'd1, 8'd2, 16'd5);
    for (int i = 3; i < 35; i++) host_write(2'd1, 8'(i), 16'($urandom_range(0, 255)));
    for (int i = 35; i < 50; i++) host_write(2'd1, 8'(i), 16'd0);
    for (int i = 0; i < 35; i++) host_write(2'd2, 8'(i), {8'h00, dmem_m[i]});
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc + dmem_m[3 + r * 4 + k] * dmem_m[15 + k * 5 + c];
        host_write(2'd2, 8'(35 + r * 5 + c), {8'h00, acc});
      end

    golden_len = 9'd50;
    launch(8'd15);
    rc_exp_q.push_back(16'd0);
    gpu_matmul();
    finish_kernel();
    for (int a = 35; a < 50; a++) begin
      dbg_addr = 8'(a); #1;
      chk("dbg_c", dbg_data, gmem_m[a]);
    end

    // corrupted golden byte
    host_write(2'd2, 8'd40, {8'h00, ~gmem_m[40]});
    launch(8'd15);
    rc_exp_q.push_back(16'd1);
    gpu_matmul();
    finish_kernel();
    for (int a = 35; a < 50; a++) begin
      dbg_addr = 8'(a); #1;
      chk("dbg_diff", dbg_data != dbg_golden, a == 40);
    end

    // handshake timing, write conflict, read-during-write
    host_write(2'd1, 8'd7, 16'h005A);
    golden_len = 9'd0;
    launch(8'd4);
    rc_exp_q.push_back(16'd0);
    rd_exp_q.push_back(16'h005A);
    gif.data_rd_valid[0] = 1'b1; gif.data_rd_addr[0] = 8'd7;
    chk("hs_rdy_pre", gif.data_rd_ready[0], 0);
    tick();
    chk("hs_rdy", gif.data_rd_ready[0], 1);
    chk("hs_data", gif.data_rd_data[0], rd_exp_q.pop_front());
    tick();
    chk("hs_hold", gif.data_rd_ready[0], 1);
    gif.data_rd_valid[0] = 1'b0;
    tick();
    chk("hs_fall", gif.data_rd_ready[0], 0);

    gif.data_wr_valid[0] = 1'b1; gif.data_wr_addr[0] = 8'd9; gif.data_wr_data[0] = 8'h11;
    gif.data_wr_valid[2] = 1'b1; gif.data_wr_addr[2] = 8'd9; gif.data_wr_data[2] = 8'h22;
    tick();
    chk("wc_rdy0", gif.data_wr_ready[0], 1);
    chk("wc_rdy2", gif.data_wr_ready[2], 1);
    gif.data_wr_valid = '0;
    tick();
    dmem_m[9] = 8'h22;

    rd_exp_q.push_back({8'h00, dmem_m[20]});
    gif.data_rd_valid[1] = 1'b1; gif.data_rd_addr[1] = 8'd20;
    gif.data_wr_valid[3] = 1'b1; gif.data_wr_addr[3] = 8'd20; gif.data_wr_data[3] = 8'hC3;
    tick();
    chk("rdw_rdy", gif.data_rd_ready[1], 1);
    chk("rdw_old", gif.data_rd_data[1], rd_exp_q.pop_front());
    chk("rdw_wr_rdy", gif.data_wr_ready[3], 1);
    gif.data_rd_valid = '0; gif.data_wr_valid = '0;
    tick();
    dmem_m[20] = 8'hC3;
    finish_kernel();
    dbg_addr = 8'd9; #1;
    chk("wc_mem", dbg_data, dmem_m[9]);
    dbg_addr = 8'd20; #1;
    chk("rdw_mem", dbg_data, dmem_m[20]);

    // reset ten cycles into RUN
    golden_len = 9'd50;
    launch(8'd15);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_gpu_rst", gif.gpu_reset, 1);
    chk("mid_rst_start", gif.gpu_start, 0);
    chk("mid_rst_rc", return_code, 0);
    seen = 1'b0;
    repeat (30) begin
      if (done) seen = 1'b1;
      tick();
    end
    chk("mid_rst_no_done", seen, 0);
    foreach (dmem_m[a]) begin
      if (a == 3 || a == 9 || a == 20 || a == 34 || a == 40 || a == 49) begin
        dbg_addr = 8'(a); #1;
        chk("keep_data", dbg_data, dmem_m[a]);
        chk("keep_golden", dbg_golden, gmem_m[a]);
      end
    end

`ifdef FW_TIMEOUT_EN
    tick();
    launch(8'd1);
    rc_exp_q.push_back(16'hFFFF);
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    chk("tmo_cycles", n, 50);
    chk("tmo_rc", return_code, rc_exp_q.pop_front());
    tick();
    chk("tmo_idle", gif.gpu_reset, 1);
`else
    n = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/kernel_test_framework.md
Name: kernel_test_framework

Overview:
- Hardware harness around the tiny GPU core.
- Owns program memory (256×16) and data memory (256×8), plus a golden image (256×8) loaded by the host.
- Launches a kernel with a given thread count, serves the GPU's memory requests until it signals done, then compares data memory against golden and reports a return code (0 = pass).

Parameters:
- DATA_CH, 4, number of GPU data-memory channels.
- PROG_CH, 1, number of GPU program-memory channels.
- MEM_LATENCY, 1, cycles from request valid to ready (≥1).
- TIMEOUT_CYCLES, 100000, watchdog limit (used only with feature enabled).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- host_we  in  1  host memory write strobe (IDLE only).
- host_sel  in  2  target: 0 = program, 1 = data, 2 = golden, 3 ignored.
- host_addr  in  8  word address.
- host_wdata  in  16  program uses [15:0]; data and golden use [7:0].
- golden_len  in  9  number of bytes to compare (0..256).
- thread_count  in  8  kernel thread count.
- run  in  1  start pulse.
- busy  out  1  high from accepted run until done.
- done  out  1  one-cycle pulse when return_code is valid.
- return_code  out  16  mismatch count, or 0xFFFF on timeout.
- dbg_addr  in  8  data-memory debug read address.
- dbg_data  out  8  data_mem[dbg_addr], combinational.
- dbg_golden  out  8  golden[dbg_addr], combinational.
- gpu_dcr_we  out  1  device control register write.
- gpu_dcr_data  out  8  thread count.
- gpu_start  out  1  kernel start level.
- gpu_reset  out  1  GPU reset.
- gpu_done  in  1  kernel complete.
- prog_rd_valid / prog_rd_addr / prog_rd_ready / prog_rd_data  in/in/out/out  PROG_CH / PROG_CH×8 / PROG_CH / PROG_CH×16.
- data_rd_valid / data_rd_addr / data_rd_ready / data_rd_data  in/in/out/out  DATA_CH / ×8 / DATA_CH / ×8.
- data_wr_valid / data_wr_addr / data_wr_data / data_wr_ready  in/in/in/out  DATA_CH / ×8 / ×8 / DATA_CH.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy, done, gpu_start, gpu_dcr_we = 0; gpu_reset = 1; return_code = 0; all ready = 0.
  - Memory contents are preserved.
- IDLE:
  - gpu_reset = 1.
  - host_we writes the selected memory in one cycle.
  - run moves to LAUNCH. run in any other state is ignored.
- LAUNCH (2 cycles):
  - Cycle 1: gpu_reset = 0, gpu_dcr_we = 1, gpu_dcr_data = thread_count.
  - Cycle 2: gpu_start = 1, then go to RUN.
- RUN:
  - gpu_start stays high.
  - Each channel is independent. On valid, a per-channel counter waits MEM_LATENCY cycles, then ready = 1 with data (reads) or the memory is written (writes).
  - ready stays high until valid drops; it falls the cycle after valid = 0.
  - Same-cycle writes to one address: the highest channel index wins.
  - A read of an address written in the same cycle returns the old value.
  - gpu_done = 1 moves to CHECK; gpu_start falls.
- CHECK:
  - Sweeps i = 0..golden_len-1, one byte per cycle.
  - Increments a mismatch counter (saturating at 0xFFFE) when data_mem[i] != golden[i].
  - golden_len = 0 gives an immediate pass.
- DONE:
  - Latches return_code, pulses done for one cycle, busy = 0, returns to IDLE (gpu_reset = 1).
- Reset asserted mid-run aborts to IDLE with return_code = 0 and done not pulsed.
- Addresses are 8-bit; no wrap handling needed beyond natural truncation.

Optional Feature:
- Macro FW_TIMEOUT_EN.
- Defined: a cycle counter runs in RUN. Reaching TIMEOUT_CYCLES without gpu_done forces DONE with return_code = 0xFFFF; CHECK is skipped and gpu_start is dropped.
- Undefined: RUN waits indefinitely; no counter logic is present.

Test Plan:
- Matmul M=3, N=4, K=5:
  - Load the 35-word matmul kernel. Data = [3,4,5] + random A (12 B) + B (20 B); golden adds C mod 256 (15 B). golden_len = 50, thread_count = 15, run.
  - Required: done pulse, return_code = 0, dbg reads of addresses 35..49 match golden.
- Corrupted golden byte:
  - Same as matmul, but golden[40] inverted.
  - Required: return_code = 1; dbg_data vs dbg_golden differ only at 40.
- Handshake timing:
  - Single channel read valid on address 7 holding 0x5A, MEM_LATENCY = 1.
  - Required: ready high with data 0x5A the cycle after valid; ready low the cycle after valid drops.
- Write conflict:
  - Channels 0 and 2 write address 9 with 0x11 and 0x22 in the same cycle.
  - Required: data_mem[9] = 0x22.
- Reset mid-RUN:
  - Assert reset 10 cycles into RUN.
  - Required: IDLE, busy = 0, done never pulses, gpu_reset = 1, memories intact.
- Timeout (FW_TIMEOUT_EN, TIMEOUT_CYCLES = 50):
  - gpu_done tied low.
  - Required: done pulses 50 cycles into RUN with return_code = 0xFFFF.
